// File: rtl/mig_tt_sweep_engine_if.sv
// Host-side bus of the MIG truth-table sweep engine: program port, start and result handshake.
interface mig_tt_sweep_engine_if #(
  parameter int unsigned N_IN    = 7,
  parameter int unsigned N_GATES = 8,
  parameter int unsigned SEL_W   = $clog2(N_IN + N_GATES + 1)
);
  localparam int unsigned AW = $clog2(N_GATES + 1);

  logic                      prog_we;
  logic [AW-1:0]             prog_addr;
  logic [3*(SEL_W+1)-1:0]    prog_data;
  logic                      start;
  logic                      busy;
  logic                      tt_valid;
  logic                      tt_ready;
  logic [(2**N_IN)-1:0]      tt;
  logic [N_IN:0]             tt_ones;

  modport master (
    output prog_we, prog_addr, prog_data, start, tt_ready,
    input  busy, tt_valid, tt, tt_ones
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, tt_ready,
    output busy, tt_valid, tt, tt_ones
  );
endinterface

// File: rtl/mig_tt_sweep_engine.sv
// Programmable MAJ-3 network evaluated over every input vector, one vector per clock,
// returning the full truth table and its population count.
module mig_tt_sweep_engine #(
  parameter int unsigned N_IN    = 7,
  parameter int unsigned N_GATES = 8,
  parameter int unsigned SEL_W   = $clog2(N_IN + N_GATES + 1)
) (
  input logic                 clk,
  input logic                 rst_n,
  mig_tt_sweep_engine_if.slave bus
);
  localparam int unsigned TT_W = 2**N_IN;
  localparam int unsigned OP_W = SEL_W + 1;
  localparam int unsigned GW   = 3 * OP_W;

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  state_e                     state_q;
  logic [N_GATES*GW-1:0]      gate_q;
  logic [OP_W-1:0]            out_q;
  logic [N_IN-1:0]            v_q;
  logic [TT_W-1:0]            tt_q;
  logic [N_IN:0]              ones_q;
  logic                       busy_q;
  logic                       valid_q;
  logic                       f;

  // lim = number of gate outputs visible to this operand; anything else reads 0.
  function automatic logic decode_op(input logic [OP_W-1:0] op, input logic [N_IN-1:0] x,
                                     input logic [N_GATES-1:0] w, input int lim);
    logic val;
    int   sel;
    val = 1'b0;
    sel = int'(op[SEL_W-1:0]);
    for (int i = 0; i < int'(N_IN); i++) begin
      if (sel == i + 1) val = x[i];
    end
    for (int k = 0; k < int'(N_GATES); k++) begin
      if (k < lim && sel == int'(N_IN) + 1 + k) val = w[k];
    end
    return val ^ op[SEL_W];
  endfunction

  function automatic logic eval_net(input logic [N_IN-1:0] x,
                                    input logic [N_GATES*GW-1:0] gates,
                                    input logic [OP_W-1:0] out_op);
    logic [N_GATES-1:0] w;
    logic               a, b, c;
    w = '0;
    for (int g = 0; g < int'(N_GATES); g++) begin
      a = decode_op(gates[g*GW +: OP_W], x, w, g);
      b = decode_op(gates[g*GW + OP_W +: OP_W], x, w, g);
      c = decode_op(gates[g*GW + 2*OP_W +: OP_W], x, w, g);
      w[g] = (a & b) | (a & c) | (b & c);
    end
    return decode_op(out_op, x, w, int'(N_GATES));
  endfunction

  always_comb begin
    f = eval_net(v_q, gate_q, out_q);
  end

  // Program registers: writable only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q <= '0;
      out_q  <= '0;
    end else if (state_q == StIdle && bus.prog_we) begin
      for (int g = 0; g < int'(N_GATES); g++) begin
        if (int'(bus.prog_addr) == g) gate_q[g*GW +: GW] <= bus.prog_data;
      end
      if (int'(bus.prog_addr) == int'(N_GATES)) out_q <= bus.prog_data[OP_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      v_q     <= '0;
      tt_q    <= '0;
      ones_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StSweep;
            v_q     <= '0;
            tt_q    <= '0;
            ones_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        StSweep: begin
          tt_q[v_q] <= f;
          ones_q    <= ones_q + (N_IN+1)'(f);
          if (&v_q) begin
            state_q <= StDone;
            valid_q <= 1'b1;
          end else begin
            v_q <= v_q + 1'b1;
          end
        end
        StDone: begin
          if (bus.tt_ready) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.tt_valid = valid_q;
  assign bus.tt       = tt_q;
  assign bus.tt_ones  = ones_q;
endmodule

// File: tb/tb_mig_tt_sweep_engine.sv
// Directed bench for mig_tt_sweep_engine with hand-computed truth tables.
module tb_mig_tt_sweep_engine;
  localparam int N_IN    = 7;
  localparam int N_GATES = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mig_tt_sweep_engine_if #(.N_IN(N_IN), .N_GATES(N_GATES)) bus ();

  mig_tt_sweep_engine #(.N_IN(N_IN), .N_GATES(N_GATES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] op(input logic inv, input int sel);
    return {inv, 4'(sel)};
  endfunction

  function automatic logic [14:0] gate(input logic [4:0] a, input logic [4:0] b,
                                       input logic [4:0] c);
    return {c, b, a};
  endfunction

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // w0 = MAJ(x0,x3,x4), f = MAJ(x0,x1,w0)
  function automatic logic [127:0] chain_tt();
    logic [127:0] t;
    logic [6:0]   x;
    for (int v = 0; v < 128; v++) begin
      x = 7'(v);
      t[v] = maj(x[0], x[1], maj(x[0], x[3], x[4]));
    end
    return t;
  endfunction

  task automatic prog(input int addr, input logic [14:0] data);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'(addr);
    bus.prog_data = data;
    @(posedge clk);
    #1 bus.prog_we = 1'b0;
  endtask

  task automatic start_sweep();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int cnt);
    cnt = 0;
    while (!bus.tt_valid && cnt < 300) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check({tag, ".valid"}, 128'(bus.tt_valid), 128'd1);
  endtask

  task automatic expect_result(input string tag, input logic [127:0] exp_tt, input int exp_ones);
    check({tag, ".tt"}, bus.tt, exp_tt);
    check({tag, ".ones"}, 128'(bus.tt_ones), 128'(exp_ones));
  endtask

  task automatic sweep(input string tag, input logic [127:0] exp_tt, input int exp_ones);
    int cnt;
    start_sweep();
    wait_done(tag, cnt);
    expect_result(tag, exp_tt, exp_ones);
  endtask

  task automatic ack(input string tag);
    bus.tt_ready = 1'b1;
    @(posedge clk);
    #1 bus.tt_ready = 1'b0;
    check({tag, ".ack_busy"}, 128'(bus.busy), 128'd0);
    check({tag, ".ack_valid"}, 128'(bus.tt_valid), 128'd0);
  endtask

  initial begin
    int           cnt;
    logic [127:0] exp_tt;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.start     = 1'b0;
    bus.tt_ready  = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;

    check("rst.busy", 128'(bus.busy), 128'd0);
    check("rst.valid", 128'(bus.tt_valid), 128'd0);
    expect_result("rst", 128'd0, 0);

    // Empty program; also measures start-to-valid latency.
    start_sweep();
    check("t1.busy", 128'(bus.busy), 128'd1);
    wait_done("t1", cnt);
    check("t1.latency", 128'(cnt), 128'd128);
    expect_result("t1", 128'd0, 0);
    ack("t1");

    // 3-input majority; output write shares the start cycle, junk in the upper data bits.
    prog(0, gate(op(0, 1), op(0, 2), op(0, 3)));
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'd8;
    bus.prog_data = {10'b1010101010, op(0, 8)};
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.prog_we = 1'b0;
    bus.start   = 1'b0;
    wait_done("t2", cnt);
    expect_result("t2", {16{8'hE8}}, 64);
    ack("t2");

    prog(0, gate(op(0, 1), op(0, 2), op(0, 0)));
    sweep("t3and", {16{8'h88}}, 32);
    ack("t3and");
    prog(8, op(1, 8));
    sweep("t3nand", {16{8'h77}}, 96);

    // Held in DONE while start and a program write are attempted.
    for (int i = 0; i < 5; i++) begin
      bus.start     = 1'b1;
      bus.prog_we   = 1'b1;
      bus.prog_addr = 4'd8;
      bus.prog_data = {10'd0, op(0, 7)};
      @(posedge clk);
      #1;
    end
    bus.start   = 1'b0;
    bus.prog_we = 1'b0;
    check("t5.valid", 128'(bus.tt_valid), 128'd1);
    check("t5.busy", 128'(bus.busy), 128'd1);
    expect_result("t5.hold", {16{8'h77}}, 96);
    ack("t5");
    sweep("t5.prog_kept", {16{8'h77}}, 96);
    ack("t5.prog_kept");

    // Output wired straight to x6.
    prog(8, op(0, 7));
    sweep("tx6", {{64{1'b1}}, {64{1'b0}}}, 64);
    ack("tx6");

    // Chain network; an output write issued mid-sweep must be dropped.
    prog(0, gate(op(0, 1), op(0, 4), op(0, 5)));
    prog(1, gate(op(0, 1), op(0, 2), op(0, 8)));
    prog(8, op(0, 9));
    start_sweep();
    repeat (3) @(posedge clk);
    #1;
    prog(8, op(0, 0));
    wait_done("t4", cnt);
    exp_tt = chain_tt();
    expect_result("t4", exp_tt, $countones(exp_tt));
    ack("t4");

    // Forward references (w5 from gate3 / gate2) read 0, complemented -> 1.
    prog(3, gate(op(0, 13), op(0, 1), op(0, 2)));
    prog(8, op(0, 11));
    sweep("t4fwd", {16{8'h88}}, 32);
    ack("t4fwd");
    prog(2, gate(op(1, 13), op(0, 1), op(0, 2)));
    prog(8, op(0, 10));
    sweep("t4fwdinv", {32{4'hE}}, 96);
    ack("t4fwdinv");

    // Asynchronous reset in the middle of a chain sweep.
    prog(8, op(0, 9));
    start_sweep();
    repeat (50) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6.busy", 128'(bus.busy), 128'd0);
    check("t6.valid", 128'(bus.tt_valid), 128'd0);
    expect_result("t6", 128'd0, 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    sweep("t6.restart", 128'd0, 0);
    ack("t6.restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
